logic_op_pipe: RTL

- Parametrised, registered successor to the single-bit combinational OR/XOR/NOT example block.
- CHANNELS independent lanes, each WIDTH bits, each with a runtime-selectable bitwise operation.
- Results pass through one valid/ready pipeline register with per-lane change detection and a saturating change-event counter.
- Sits between a stimulus/source stage and any valid/ready consumer, e.g. a monitor or scoreboard.

---
 rtl/logic_op_pipe_if.sv | 25 ++
 rtl/logic_op_pipe.sv | 81 ++++++++
 2 files changed

// File: rtl/logic_op_pipe_if.sv
// logic_op_pipe_if: valid/ready beat bus for logic_op_pipe.
// out_par exists only when LOGIC_OP_PIPE_PARITY_EN is defined.
interface logic_op_pipe_if #(
  parameter int WIDTH = 1,
  parameter int CHANNELS = 3,
  parameter int CNT_W = 8
);
  logic in_valid, in_ready, out_valid, out_ready, clr_count;
  logic [CHANNELS*WIDTH-1:0] in_a, in_b, out_y;
  logic [2*CHANNELS-1:0] op_sel;
  logic [CHANNELS-1:0] chg_mask;
  logic [CNT_W-1:0] chg_count;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic [CHANNELS-1:0] out_par;
  modport master(output in_valid, in_a, in_b, op_sel, out_ready, clr_count,
                 input in_ready, out_valid, out_y, chg_mask, chg_count, out_par);
  modport slave(input in_valid, in_a, in_b, op_sel, out_ready, clr_count,
                output in_ready, out_valid, out_y, chg_mask, chg_count, out_par);
`else
  modport master(output in_valid, in_a, in_b, op_sel, out_ready, clr_count,
                 input in_ready, out_valid, out_y, chg_mask, chg_count);
  modport slave(input in_valid, in_a, in_b, op_sel, out_ready, clr_count,
                output in_ready, out_valid, out_y, chg_mask, chg_count);
`endif
endinterface

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: per-lane OR/XOR/AND/NOT behind one valid/ready register with change tracking.
// Optional per-lane parity output enabled by LOGIC_OP_PIPE_PARITY_EN.
module logic_op_pipe #(
  parameter int WIDTH = 1,
  parameter int CHANNELS = 3,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  logic_op_pipe_if.slave io
);
  localparam int N = CHANNELS * WIDTH;
  logic valid_q, valid_d, rdy, acc;
  logic [N-1:0] y_q, y_d, res;
  logic [CHANNELS-1:0] mask_q, mask_d, chg;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] la, lb;
  logic [1:0] op;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic [CHANNELS-1:0] par, par_q, par_d;
`endif
  // out_y doubles as the history register: both load only on accept and reset to 0
  always_comb begin
    res = '0;
    chg = '0;
    la = '0;
    lb = '0;
    op = '0;
`ifdef LOGIC_OP_PIPE_PARITY_EN
    par = '0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      la = io.in_a[i*WIDTH +: WIDTH];
      lb = io.in_b[i*WIDTH +: WIDTH];
      op = io.op_sel[2*i +: 2];
      res[i*WIDTH +: WIDTH] = op == 2'd0 ? la | lb : op == 2'd1 ? la ^ lb : op == 2'd2 ? la & lb : ~la;
      chg[i] = |(res[i*WIDTH +: WIDTH] ^ y_q[i*WIDTH +: WIDTH]);
`ifdef LOGIC_OP_PIPE_PARITY_EN
      par[i] = ^res[i*WIDTH +: WIDTH];
`endif
    end
  end
  always_comb begin
    rdy = !valid_q || io.out_ready;
    acc = io.in_valid && rdy;
    valid_d = acc ? 1'b1 : io.out_ready ? 1'b0 : valid_q;
    y_d = acc ? res : y_q;
    mask_d = acc ? chg : mask_q;
    cnt_d = io.clr_count ? '0 : (acc && |chg && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
`ifdef LOGIC_OP_PIPE_PARITY_EN
    par_d = acc ? par : par_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      y_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
`ifdef LOGIC_OP_PIPE_PARITY_EN
      par_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      y_q <= y_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
`ifdef LOGIC_OP_PIPE_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  assign io.in_ready = rdy;
  assign io.out_valid = valid_q;
  assign io.out_y = y_q;
  assign io.chg_mask = mask_q;
  assign io.chg_count = cnt_q;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  assign io.out_par = par_q;
`endif
endmodule
